// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_unit_if : controller / EX-MEM / fetch-stage signal bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if #(
   parameter int LINK_DEPTH = 4
);
   localparam int c_COUNT_W = $clog2(LINK_DEPTH) + 1;

   logic [1:0]           PCControl;
   logic [15:0]          InstrIn;
   logic                 MEM_Jump;
   logic                 MEM_Branch;
   logic                 MEM_ALUZero;
   logic [3:0]           MEM_OpCode;
   logic [15:0]          MEM_JumpAddr;
   logic [15:0]          MEM_BranchAddr;
   logic [15:0]          PC;
   logic [15:0]          IFID_Instr;
   logic [15:0]          IFID_PCPlus2;
   logic [c_COUNT_W-1:0] LinkCount;
   logic                 StackErr;

   modport master (
      output PCControl, InstrIn, MEM_Jump, MEM_Branch, MEM_ALUZero,
             MEM_OpCode, MEM_JumpAddr, MEM_BranchAddr,
      input  PC, IFID_Instr, IFID_PCPlus2, LinkCount, StackErr
   );

   modport slave (
      input  PCControl, InstrIn, MEM_Jump, MEM_Branch, MEM_ALUZero,
             MEM_OpCode, MEM_JumpAddr, MEM_BranchAddr,
      output PC, IFID_Instr, IFID_PCPlus2, LinkCount, StackErr
   );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_unit : PMIPSL0 program counter, IF/ID register and return-link stack
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          LINK_DEPTH = 4
) (
   input  wire             clock,
   input  wire             reset,
   fetch_pc_unit_if.slave  bus
);
   localparam int               c_PTR_W    = $clog2(LINK_DEPTH);
   localparam int               c_COUNT_W  = c_PTR_W + 1;
   localparam logic [15:0]      c_ADDR_MSK = 16'hFFFE;
   localparam logic [15:0]      c_RST_PC   = RESET_PC & c_ADDR_MSK;
   localparam logic [c_COUNT_W-1:0] c_FULL = c_COUNT_W'(LINK_DEPTH);

   localparam logic [1:0] c_CTL_INC   = 2'd1;
   localparam logic [1:0] c_CTL_CLOAD = 2'd2;
   localparam logic [3:0] c_OP_JAL    = 4'd9;
   localparam logic [3:0] c_OP_RET    = 4'd10;

   logic [15:0]          r_pc;
   logic [15:0]          r_ifid_instr;
   logic [15:0]          r_ifid_pcplus2;
   logic [c_COUNT_W-1:0] r_link_count;
   logic [c_PTR_W-1:0]   r_sp;
   logic [15:0]          r_stack [LINK_DEPTH];
   logic                 r_stack_err;

   logic [15:0]          w_pc_plus2;
   logic [c_PTR_W-1:0]   w_sp_dec;

   assign w_pc_plus2 = r_pc + 16'd2;
   // Depth is a power of two, so the pointer wraps by natural overflow.
   assign w_sp_dec   = r_sp - 1'b1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_pc           <= c_RST_PC;
         r_ifid_instr   <= 16'h0000;
         r_ifid_pcplus2 <= 16'h0000;
         r_link_count   <= '0;
         r_sp           <= '0;
         r_stack_err    <= 1'b0;
      end else begin
         case (bus.PCControl)
            c_CTL_INC: begin
               r_pc           <= w_pc_plus2;
               r_ifid_instr   <= bus.InstrIn;
               r_ifid_pcplus2 <= w_pc_plus2;
            end
            c_CTL_CLOAD: begin
               if (bus.MEM_Jump) begin
                  case (bus.MEM_OpCode)
                     c_OP_JAL: begin
                        // PC already holds the return address when jal retires.
                        r_stack[r_sp] <= r_pc;
                        r_sp          <= r_sp + 1'b1;
                        if (r_link_count == c_FULL)
                           r_stack_err  <= 1'b1;
                        else
                           r_link_count <= r_link_count + 1'b1;
                        r_pc <= bus.MEM_JumpAddr & c_ADDR_MSK;
                     end
                     c_OP_RET: begin
                        if (r_link_count != '0) begin
                           r_pc         <= r_stack[w_sp_dec];
                           r_sp         <= w_sp_dec;
                           r_link_count <= r_link_count - 1'b1;
                        end else begin
                           r_stack_err  <= 1'b1;
                        end
                     end
                     default: r_pc <= bus.MEM_JumpAddr & c_ADDR_MSK;
                  endcase
               end else if (bus.MEM_Branch && bus.MEM_ALUZero) begin
                  r_pc <= bus.MEM_BranchAddr & c_ADDR_MSK;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.PC           = r_pc;
   assign bus.IFID_Instr   = r_ifid_instr;
   assign bus.IFID_PCPlus2 = r_ifid_pcplus2;
   assign bus.LinkCount    = r_link_count;
   assign bus.StackErr     = r_stack_err;
endmodule
`default_nettype wire
